// File: rtl/password_checker.sv
// password_checker: debounces a 4-bit digit code into key presses, collects a fixed-length code and checks it
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   num        in   digit code, 0-9 digit, 10-15 no key
//   clear      in   synchronous abort / relock request
//   digit_leds out  one-hot of last accepted digit
//   count      out  digits accepted in the current entry
//   unlocked   out  high while open
//   error      out  high while showing a failed attempt
//   locked     out  high during lockout
//   fails      out  consecutive failure count
module password_checker #(
    parameter int DIGITS = 4,
    parameter logic [4*DIGITS-1:0] PASSWORD = 16'h1234,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int OPEN_CYCLES = 100_000_000,
    parameter int ERR_CYCLES = 50_000_000,
    parameter int MAX_FAILS = 3,
    parameter int LOCK_CYCLES = 500_000_000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [3:0]                       num,
    input  logic                             clear,
    output logic [9:0]                       digit_leds,
    output logic [3:0]                       count,
    output logic                             unlocked,
    output logic                             error,
    output logic                             locked,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fails
);
    localparam int CW = 4 * DIGITS;
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TMAX = OPEN_CYCLES > ERR_CYCLES ? (OPEN_CYCLES > LOCK_CYCLES ? OPEN_CYCLES : LOCK_CYCLES)
                                                   : (ERR_CYCLES > LOCK_CYCLES ? ERR_CYCLES : LOCK_CYCLES);
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [2:0] S_ENTRY = 3'd0, S_CHECK = 3'd1, S_OPEN = 3'd2, S_FAIL = 3'd3, S_LOCK = 3'd4;
    logic [2:0]    state;
    logic [3:0]    num_f, num_q, acc_d;
    logic [SW-1:0] stab;
    logic          armed, acc, press, rel, stable;
    logic [CW-1:0] code;
    logic [TW-1:0] timer;
    assign num_f = num > 4'd9 ? 4'd10 : num;
    assign stable = stab == SW'(STABLE_CYCLES);
    assign press = armed && num_q <= 4'd9 && stable;
    assign rel = !armed && num_q == 4'd10 && stable;
    assign unlocked = state == S_OPEN;
    assign error = state == S_FAIL;
    assign locked = state == S_LOCK;
    // Debouncer runs in every state so a key held across a state change stays disarmed.
    // The accept pulse is registered with its digit, so it lands one edge after the press is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q <= 4'd10;
            stab  <= '0;
            armed <= 1'b1;
            acc   <= 1'b0;
            acc_d <= 4'd0;
        end else begin
            num_q <= num_f;
            stab  <= num_f != num_q ? SW'(1) : stable ? stab : stab + 1'b1;
            acc   <= press;
            acc_d <= num_q;
            armed <= press ? 1'b0 : rel ? 1'b1 : armed;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_ENTRY;
            code       <= '0;
            count      <= 4'd0;
            digit_leds <= 10'd0;
            fails      <= '0;
            timer      <= '0;
        end else begin
            case (state)
                S_ENTRY: begin
                    if (clear) begin
                        count      <= 4'd0;
                        code       <= '0;
                        digit_leds <= 10'd0;
                    end else if (count == 4'(DIGITS)) begin
                        state      <= S_CHECK;
                        digit_leds <= 10'd0;
                    end else if (acc) begin
                        code       <= CW'({code, acc_d});
                        count      <= count + 4'd1;
                        digit_leds <= 10'd1 << acc_d;
                    end
                end
                S_CHECK: begin
                    count <= 4'd0;
                    timer <= '0;
                    state <= code == PASSWORD ? S_OPEN : S_FAIL;
                    fails <= code == PASSWORD ? '0 : fails + 1'b1;
                end
                S_OPEN: begin
                    state <= clear || timer == TW'(OPEN_CYCLES - 1) ? S_ENTRY : S_OPEN;
                    timer <= clear || timer == TW'(OPEN_CYCLES - 1) ? '0 : timer + 1'b1;
                end
                S_FAIL: begin
                    state <= timer != TW'(ERR_CYCLES - 1) ? S_FAIL : fails == FW'(MAX_FAILS) ? S_LOCK : S_ENTRY;
                    timer <= timer == TW'(ERR_CYCLES - 1) ? '0 : timer + 1'b1;
                end
                S_LOCK: begin
                    state <= timer == TW'(LOCK_CYCLES - 1) ? S_ENTRY : S_LOCK;
                    fails <= timer == TW'(LOCK_CYCLES - 1) ? '0 : fails;
                    timer <= timer == TW'(LOCK_CYCLES - 1) ? '0 : timer + 1'b1;
                end
                default: state <= S_ENTRY;
            endcase
        end
    end
endmodule

// File: tb/tb_password_checker.sv
// tb_password_checker: random and directed stimulus against a behavioural model of the code lock
module tb_password_checker;
    localparam int STAB = 4, OPEN = 8, ERR = 4, LOCK = 16, DIG = 4, MAXF = 3;
    localparam logic [15:0] PW = 16'h1234;
    localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_FAIL = 3, M_LOCK = 4;

    logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    logic [3:0] num = 4'd10;
    logic [9:0] digit_leds;
    logic [3:0] count;
    logic       unlocked, error, locked;
    logic [1:0] fails;

    always #5 clk = ~clk;

    password_checker #(
        .DIGITS(DIG), .PASSWORD(PW), .STABLE_CYCLES(STAB), .OPEN_CYCLES(OPEN),
        .ERR_CYCLES(ERR), .MAX_FAILS(MAXF), .LOCK_CYCLES(LOCK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .num(num), .clear(clear), .digit_leds(digit_leds),
        .count(count), .unlocked(unlocked), .error(error), .locked(locked), .fails(fails)
    );

    int tests = 0, errors = 0;
    int hi_unl = 0, hi_err = 0, hi_lock = 0;

    // Reference model: run length of the folded input, pending press, digits entered so far,
    // and a countdown of the remaining cycles of the current indication.
    int mlast, mrun, macc_d, mst, remain, mleds, mfails, f;
    bit marmed, macc, pr, rl, ok;
    int entered[$];

    function automatic int pw_digit(input int i);
        return int'((PW >> (4 * (DIG - 1 - i))) & 16'hF);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mlast = 10; mrun = 0; marmed = 1; macc = 0; macc_d = 0;
            mst = M_ENTRY; remain = 0; mleds = 0; mfails = 0;
            entered.delete();
        end else begin
            case (mst)
                M_ENTRY: begin
                    if (clear) begin
                        entered.delete();
                        mleds = 0;
                    end else if (entered.size() == DIG) begin
                        mst = M_CHECK;
                        mleds = 0;
                    end else if (macc) begin
                        entered.push_back(macc_d);
                        mleds = 1 << macc_d;
                    end
                end
                M_CHECK: begin
                    ok = 1;
                    for (int i = 0; i < DIG; i++) if (entered[i] != pw_digit(i)) ok = 0;
                    entered.delete();
                    if (ok) begin mst = M_OPEN; remain = OPEN; mfails = 0; end
                    else begin mst = M_FAIL; remain = ERR; mfails++; end
                end
                M_OPEN: begin
                    remain--;
                    if (clear || remain == 0) mst = M_ENTRY;
                end
                M_FAIL: begin
                    remain--;
                    if (remain == 0) begin
                        if (mfails == MAXF) begin mst = M_LOCK; remain = LOCK; end
                        else mst = M_ENTRY;
                    end
                end
                default: begin
                    remain--;
                    if (remain == 0) begin mst = M_ENTRY; mfails = 0; end
                end
            endcase
            pr = marmed && mlast <= 9 && mrun >= STAB;
            rl = !marmed && mlast == 10 && mrun >= STAB;
            macc = pr;
            macc_d = mlast;
            if (pr) marmed = 0;
            else if (rl) marmed = 1;
            f = num > 9 ? 10 : int'(num);
            mrun = f == mlast ? mrun + 1 : 1;
            mlast = f;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n, input bit c);
        num = 4'(n);
        clear = c;
        @(posedge clk);
        #1;
        check("leds", int'(digit_leds), mleds);
        check("count", int'(count), entered.size());
        check("unlocked", int'(unlocked), int'(mst == M_OPEN));
        check("error", int'(error), int'(mst == M_FAIL));
        check("locked", int'(locked), int'(mst == M_LOCK));
        check("fails", int'(fails), mfails);
        hi_unl += int'(unlocked);
        hi_err += int'(error);
        hi_lock += int'(locked);
    endtask

    task automatic key(input int d, input int hold, input int gap);
        repeat (hold) cyc(d, 0);
        repeat (gap) cyc(10, 0);
    endtask

    task automatic enter(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) key(int'(v[4*i +: 4]), 6, 6);
    endtask

    task automatic zero_outs(input string tag);
        check({tag, "_leds"}, int'(digit_leds), 0);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_unl"}, int'(unlocked), 0);
        check({tag, "_err"}, int'(error), 0);
        check({tag, "_lock"}, int'(locked), 0);
        check({tag, "_fails"}, int'(fails), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        zero_outs("reset");
        rst_n = 1'b1;
        repeat (4) cyc(10, 0);

        // correct code
        hi_unl = 0;
        key(1, 6, 6);
        check("first_count", int'(count), 1);
        check("first_leds", int'(digit_leds), 10'b0000000010);
        key(2, 6, 6);
        check("second_count", int'(count), 2);
        key(3, 6, 6);
        key(4, 6, 6);
        repeat (20) cyc(10, 0);
        check("open_len", hi_unl, OPEN);
        check("open_fails", int'(fails), 0);

        // bounce rejection
        repeat (3) cyc(5, 0);
        repeat (2) cyc(10, 0);
        repeat (3) cyc(5, 0);
        repeat (6) cyc(10, 0);
        check("bounce_none", int'(count), 0);
        key(5, 7, 3);
        key(5, 3, 6);
        check("bounce_one", int'(count), 1);
        repeat (6) cyc(5, 0);
        repeat (6) cyc(6, 0);
        repeat (6) cyc(10, 0);
        check("direct_change", int'(count), 2);
        cyc(10, 1);
        check("bounce_clr", int'(count), 0);

        // three wrong codes, then lockout
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin hi_err = 0; hi_lock = 0; end
            enter(16'h1111);
            check("fails_step", int'(fails), i + 1);
            if (i < 2) repeat (6) cyc(10, 0);
        end
        key(7, 6, 6);
        check("lock_count", int'(count), 0);
        repeat (10) cyc(10, 0);
        check("err_len", hi_err, ERR);
        check("lock_len", hi_lock, LOCK);
        check("lock_fails", int'(fails), 0);

        // clear
        key(1, 6, 6);
        key(2, 6, 6);
        check("pre_clr_count", int'(count), 2);
        cyc(10, 1);
        check("clr_count", int'(count), 0);
        check("clr_leds", int'(digit_leds), 0);
        for (int i = 0; i < 6; i++) cyc(3, i == 5);
        repeat (6) cyc(10, 0);
        check("clr_accept", int'(count), 0);
        enter(PW);
        for (int w = 0; w < 40 && !unlocked; w++) cyc(10, 0);
        check("open_seen", int'(unlocked), 1);
        cyc(10, 1);
        check("open_clr", int'(unlocked), 0);
        repeat (4) cyc(10, 0);

        // wrong then right, key held from FAIL into ENTRY
        key(1, 6, 6);
        key(1, 6, 6);
        key(1, 6, 6);
        repeat (20) cyc(1, 0);
        repeat (6) cyc(10, 0);
        check("wr_fails", int'(fails), 1);
        check("held_key", int'(count), 0);
        enter(PW);
        check("wr_open", int'(unlocked), 1);
        check("wr_fails0", int'(fails), 0);
        repeat (12) cyc(10, 0);

        // reset during lockout
        for (int i = 0; i < 3; i++) begin
            enter(16'h1111);
            if (i < 2) repeat (6) cyc(10, 0);
        end
        repeat (3) cyc(10, 0);
        check("pre_rst_lock", int'(locked), 1);
        #2 rst_n = 1'b0;
        #1;
        zero_outs("async");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cyc(10, 0);
        check("post_rst_lock", int'(locked), 0);
        check("post_rst_fails", int'(fails), 0);
        hi_unl = 0;
        enter(PW);
        repeat (10) cyc(10, 0);
        check("post_rst_open", hi_unl, OPEN);

        // randomized traffic against the model
        repeat (300) begin
            if ($urandom_range(0, 5) == 0) begin
                enter($urandom_range(0, 1) == 0 ? PW : 16'(32'h1230 + $urandom_range(0, 9)));
            end else begin
                int d = $urandom_range(0, 11);
                repeat ($urandom_range(1, 8)) cyc(d, $urandom_range(0, 29) == 0);
                repeat ($urandom_range(1, 8)) cyc($urandom_range(10, 15), $urandom_range(0, 29) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
